// File: rtl/cache_maint_seq_if.sv
// ---------------------------------------------------------------------------
// cache_maint_seq_if
//   Bundles the command handshake, the tag/state RAM access signals and the
//   write-back handshake of the cache maintenance sequencer.
//
//   Signals
//     cmd            3  maintenance command from the control-register block
//     cmd_ready      1  one-cycle pulse when a walk has completed
//     busy           1  sequencer is walking; CPU-side cache port must stall
//     tag_set    SET_W  set index for tag RAM and write-back access
//     tag_way    WAY_W  way index for tag RAM and write-back access
//     tag_read       1  tag-state read strobe (data valid on the next cycle)
//     tag_valid_in   1  valid bit returned by the tag RAM
//     tag_dirty_in   1  dirty bit returned by the tag RAM
//     tag_write      1  tag-state write strobe
//     tag_valid_out  1  valid bit to write
//     tag_dirty_out  1  dirty bit to write
//     wb_req         1  request write-back of line (tag_set, tag_way)
//     wb_ack         1  write-back complete
//
//   Modports
//     master : the sequencer side
//     slave  : the control block / tag RAM / write-back side
// ---------------------------------------------------------------------------
interface cache_maint_seq_if #(
  parameter int SET_NUM = 64,
  parameter int WAY_NUM = 4
);
  localparam int SET_W = $clog2(SET_NUM);
  localparam int WAY_W = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

  logic [2:0]       cmd;
  logic             cmd_ready;
  logic             busy;
  logic [SET_W-1:0] tag_set;
  logic [WAY_W-1:0] tag_way;
  logic             tag_read;
  logic             tag_valid_in;
  logic             tag_dirty_in;
  logic             tag_write;
  logic             tag_valid_out;
  logic             tag_dirty_out;
  logic             wb_req;
  logic             wb_ack;

  modport master (
    input  cmd,
    input  tag_valid_in,
    input  tag_dirty_in,
    input  wb_ack,
    output cmd_ready,
    output busy,
    output tag_set,
    output tag_way,
    output tag_read,
    output tag_write,
    output tag_valid_out,
    output tag_dirty_out,
    output wb_req
  );

  modport slave (
    output cmd,
    output tag_valid_in,
    output tag_dirty_in,
    output wb_ack,
    input  cmd_ready,
    input  busy,
    input  tag_set,
    input  tag_way,
    input  tag_read,
    input  tag_write,
    input  tag_valid_out,
    input  tag_dirty_out,
    input  wb_req
  );
endinterface

// File: rtl/cache_maint_seq.sv
// ---------------------------------------------------------------------------
// cache_maint_seq
//   Cache maintenance sequencer. Accepts an init / clear / write-back command
//   and walks every (set, way) of the cache in ascending index order:
//     init  : writes valid=0, dirty=0 to every line, one line per cycle.
//     clear : reads each line, writes back dirty lines, then invalidates.
//     wb    : reads each line, writes back dirty lines and marks them clean;
//             clean or invalid lines are left untouched.
//   cmd_ready pulses for one cycle at the end of the walk; busy is high for
//   the whole walk so the CPU-side port can stall.
//
//   Ports
//     clk   input   clock
//     rest  input   asynchronous active-low reset
//     bus   master  cache_maint_seq_if (command, tag RAM, write-back)
//
//   All outputs are decoded from the state/index registers only, so they
//   fall to zero as soon as rest is asserted.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | waiting for a non-nop command
//   INIT_WR  | init walk: write valid=0/dirty=0 to line idx
//   READ     | issue tag read for line idx
//   CHECK    | tag data present; decide write-back / update / advance
//   WB_REQ   | hold wb_req for line idx until wb_ack
//   UPDATE   | write new valid/dirty for line idx
//   DONE     | one-cycle cmd_ready pulse, then back to IDLE
// ---------------------------------------------------------------------------
`ifndef CACHE_CTR_CMD_NOP
`define CACHE_CTR_CMD_NOP   3'b000
`endif
`ifndef CACHE_CTR_CMD_INIT
`define CACHE_CTR_CMD_INIT  3'b001
`endif
`ifndef CACHE_CTR_CMD_CLEAR
`define CACHE_CTR_CMD_CLEAR 3'b010
`endif
`ifndef CACHE_CTR_CMD_WB
`define CACHE_CTR_CMD_WB    3'b011
`endif

module cache_maint_seq #(
  parameter int SET_NUM = 64,
  parameter int WAY_NUM = 4
) (
  input  logic               clk,
  input  logic               rest,
  cache_maint_seq_if.master  bus
);

  localparam int SET_W = $clog2(SET_NUM);
  localparam int WAY_W = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
  localparam int IDX_W = SET_W + WAY_W;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SET_NUM * WAY_NUM - 1);

  localparam logic [2:0] CMD_NOP   = `CACHE_CTR_CMD_NOP;
  localparam logic [2:0] CMD_INIT  = `CACHE_CTR_CMD_INIT;
  localparam logic [2:0] CMD_CLEAR = `CACHE_CTR_CMD_CLEAR;
  localparam logic [2:0] CMD_WB    = `CACHE_CTR_CMD_WB;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_WR,
    S_READ,
    S_CHECK,
    S_WB_REQ,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       op_q, op_d;
  logic             last_line;

  assign last_line = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      op_q    <= CMD_NOP;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        // Unknown encodings are not latched so a stray value cannot start
        // a walk with an undefined operation.
        if (bus.cmd == CMD_INIT) begin
          op_d    = bus.cmd;
          idx_d   = '0;
          state_d = S_INIT_WR;
        end else if ((bus.cmd == CMD_CLEAR) || (bus.cmd == CMD_WB)) begin
          op_d    = bus.cmd;
          idx_d   = '0;
          state_d = S_READ;
        end
      end
      S_INIT_WR: begin
        if (last_line) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_READ: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (bus.tag_valid_in && bus.tag_dirty_in) begin
          state_d = S_WB_REQ;
        end else if (op_q == CMD_CLEAR) begin
          state_d = S_UPDATE;
        end else if (last_line) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_READ;
        end
      end
      S_WB_REQ: begin
        if (bus.wb_ack) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (last_line) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line index split: way in the low bits so ways of a set are adjacent.
  if (WAY_NUM == 1) begin : g_one_way
    assign bus.tag_way = '0;
    assign bus.tag_set = idx_q[SET_W-1:0];
  end else begin : g_multi_way
    assign bus.tag_way = idx_q[WAY_W-1:0];
    assign bus.tag_set = idx_q[IDX_W-1:WAY_W];
  end

  assign bus.busy          = (state_q != S_IDLE);
  assign bus.cmd_ready     = (state_q == S_DONE);
  assign bus.tag_read      = (state_q == S_READ);
  assign bus.wb_req        = (state_q == S_WB_REQ);
  assign bus.tag_write     = (state_q == S_INIT_WR) || (state_q == S_UPDATE);
  // Only a write-back update leaves the line valid; init and clear both
  // invalidate. Every rewrite leaves the line clean.
  assign bus.tag_valid_out = (state_q == S_UPDATE) && (op_q == CMD_WB);
  assign bus.tag_dirty_out = 1'b0;

endmodule

// File: tb/tb_cache_maint_seq.sv
// ---------------------------------------------------------------------------
// tb_cache_maint_seq
//   Scoreboard bench for cache_maint_seq (SET_NUM=4, WAY_NUM=2). The driver
//   computes, from the tag RAM image at issue time, the ordered list of
//   write-back requests, tag writes and the completion pulse a walk must
//   produce, plus the walk length in cycles, and queues them. A monitor
//   pops and compares whenever the DUT shows one of those outputs.
// ---------------------------------------------------------------------------
`ifndef CACHE_CTR_CMD_NOP
`define CACHE_CTR_CMD_NOP   3'b000
`endif
`ifndef CACHE_CTR_CMD_INIT
`define CACHE_CTR_CMD_INIT  3'b001
`endif
`ifndef CACHE_CTR_CMD_CLEAR
`define CACHE_CTR_CMD_CLEAR 3'b010
`endif
`ifndef CACHE_CTR_CMD_WB
`define CACHE_CTR_CMD_WB    3'b011
`endif

module tb_cache_maint_seq;
  localparam int SET_NUM = 4;
  localparam int WAY_NUM = 2;
  localparam int N       = SET_NUM * WAY_NUM;

  localparam logic [2:0] C_NOP   = `CACHE_CTR_CMD_NOP;
  localparam logic [2:0] C_INIT  = `CACHE_CTR_CMD_INIT;
  localparam logic [2:0] C_CLEAR = `CACHE_CTR_CMD_CLEAR;
  localparam logic [2:0] C_WB    = `CACHE_CTR_CMD_WB;

  localparam int EV_WR   = 0;
  localparam int EV_WB   = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int kind;
    int set;
    int way;
    int v;
    int d;
    int len;
  } ev_t;

  logic clk = 1'b0;
  logic rest = 1'b0;

  cache_maint_seq_if #(.SET_NUM(SET_NUM), .WAY_NUM(WAY_NUM)) bus_if ();

  cache_maint_seq #(.SET_NUM(SET_NUM), .WAY_NUM(WAY_NUM)) dut (
    .clk  (clk),
    .rest (rest),
    .bus  (bus_if.master)
  );

  always #5 clk = ~clk;

  ev_t exp_q[$];
  int  cyc_q[$];
  bit  ram_v[N];
  bit  ram_d[N];
  int  wb_dly[N];
  int  tests = 0;
  int  fails = 0;

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void flag(string name);
    tests++;
    fails++;
    $display("FAIL %s at %0t", name, $time);
  endfunction

  // Reference model: what a walk of 'op' over the current RAM image produces.
  function automatic void push_expect(logic [2:0] op);
    int  cyc;
    ev_t e;
    cyc = 1;  // DONE cycle
    for (int i = 0; i < N; i++) begin
      e.set = i / WAY_NUM;
      e.way = i % WAY_NUM;
      e.v   = 0;
      e.d   = 0;
      e.len = 0;
      if (op == C_INIT) begin
        e.kind = EV_WR;
        exp_q.push_back(e);
        cyc += 1;
      end else begin
        cyc += 2;
        if (ram_v[i] && ram_d[i]) begin
          e.kind = EV_WB;
          e.len  = wb_dly[i] + 1;
          exp_q.push_back(e);
          cyc += e.len;
        end
        if ((ram_v[i] && ram_d[i]) || (op == C_CLEAR)) begin
          e.kind = EV_WR;
          e.v    = (op == C_WB) ? 1 : 0;
          e.len  = 0;
          exp_q.push_back(e);
          cyc += 1;
        end
      end
    end
    e.kind = EV_DONE;
    e.set  = 0;
    e.way  = 0;
    e.v    = 0;
    e.len  = 0;
    exp_q.push_back(e);
    cyc_q.push_back(cyc);
  endfunction

  // Tag RAM and write-back responder.
  initial begin : responder
    int  k;
    bit  hold;
    int  ln;
    k    = 0;
    hold = 0;
    bus_if.tag_valid_in = 1'b0;
    bus_if.tag_dirty_in = 1'b0;
    bus_if.wb_ack       = 1'b0;
    forever begin
      @(negedge clk);
      ln = int'(bus_if.tag_set) * WAY_NUM + int'(bus_if.tag_way);
      if (bus_if.tag_read) begin
        bus_if.tag_valid_in = ram_v[ln];
        bus_if.tag_dirty_in = ram_d[ln];
        hold = 1;
      end else if (hold) begin
        hold = 0;
      end else begin
        bus_if.tag_valid_in = 1'($urandom);
        bus_if.tag_dirty_in = 1'($urandom);
      end
      if (bus_if.wb_req) begin
        k++;
        bus_if.wb_ack = (k == wb_dly[ln] + 1);
      end else begin
        k = 0;
        bus_if.wb_ack = 1'($urandom);
      end
    end
  end

  // Monitor / scoreboard.
  initial begin : monitor
    bit  prev_wb, prev_busy, prev_rdy;
    int  bcnt, wlen, wexp, wset, wway, ln;
    ev_t e;
    prev_wb = 0; prev_busy = 0; prev_rdy = 0;
    bcnt = 0; wlen = 0; wexp = 0; wset = 0; wway = 0;
    forever begin
      @(negedge clk);
      if (!rest) begin
        prev_wb = 0; prev_busy = 0; prev_rdy = 0; bcnt = 0; wlen = 0;
      end else begin
        if (bus_if.busy)
          check("strobe_exclusive",
                int'(bus_if.tag_read) + int'(bus_if.tag_write) + int'(bus_if.wb_req) <= 1 ? 1 : 0, 1);
        if (prev_rdy) check("idle_after_ready", int'(bus_if.busy), 0);

        if (bus_if.tag_write) begin
          if (exp_q.size() == 0) flag("unexpected_tag_write");
          else begin
            e = exp_q.pop_front();
            check("write_kind", EV_WR, e.kind);
            check("write_set", int'(bus_if.tag_set), e.set);
            check("write_way", int'(bus_if.tag_way), e.way);
            check("write_valid", int'(bus_if.tag_valid_out), e.v);
            check("write_dirty", int'(bus_if.tag_dirty_out), e.d);
          end
          ln = int'(bus_if.tag_set) * WAY_NUM + int'(bus_if.tag_way);
          ram_v[ln] = bus_if.tag_valid_out;
          ram_d[ln] = bus_if.tag_dirty_out;
        end

        if (bus_if.wb_req && !prev_wb) begin
          wset = int'(bus_if.tag_set);
          wway = int'(bus_if.tag_way);
          wlen = 1;
          wexp = 0;
          if (exp_q.size() == 0) flag("unexpected_wb_req");
          else begin
            e = exp_q.pop_front();
            check("wb_kind", EV_WB, e.kind);
            check("wb_set", wset, e.set);
            check("wb_way", wway, e.way);
            wexp = e.len;
          end
        end else if (bus_if.wb_req) begin
          wlen++;
          check("wb_set_stable", int'(bus_if.tag_set), wset);
          check("wb_way_stable", int'(bus_if.tag_way), wway);
        end
        if (prev_wb && !bus_if.wb_req) check("wb_req_cycles", wlen, wexp);

        if (bus_if.cmd_ready) begin
          if (exp_q.size() == 0) flag("unexpected_cmd_ready");
          else begin
            e = exp_q.pop_front();
            check("done_kind", EV_DONE, e.kind);
          end
        end

        if (bus_if.busy) begin
          if (!prev_busy && cyc_q.size() == 0) flag("unexpected_busy");
          bcnt = prev_busy ? bcnt + 1 : 1;
        end else if (prev_busy) begin
          if (cyc_q.size() == 0) flag("unexpected_walk_end");
          else check("walk_cycles", bcnt, cyc_q.pop_front());
        end

        prev_wb   = bus_if.wb_req;
        prev_busy = bus_if.busy;
        prev_rdy  = bus_if.cmd_ready;
      end
    end
  end

  task automatic wait_busy(output int n);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n++;
      if (bus_if.busy) return;
    end
    flag("busy_timeout");
  endtask

  task automatic wait_ready();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (bus_if.cmd_ready) return;
    end
    flag("ready_timeout");
  endtask

  // Called just after a negedge with the DUT idle.
  task automatic drive_walk(input logic [2:0] op, input logic [2:0] mid,
                            input logic [2:0] after);
    int g;
    bus_if.cmd = op;
    wait_busy(g);
    bus_if.cmd = mid;
    wait_ready();
    bus_if.cmd = after;
  endtask

  task automatic rand_ram();
    for (int i = 0; i < N; i++) begin
      ram_v[i]  = 1'($urandom);
      ram_d[i]  = 1'($urandom);
      wb_dly[i] = int'($urandom_range(0, 3));
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog_timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin : driver
    int g;
    logic [2:0] op;
    bus_if.cmd = C_NOP;
    rand_ram();

    // Reset state.
    @(negedge clk);
    #1;
    check("rst_busy", int'(bus_if.busy), 0);
    check("rst_cmd_ready", int'(bus_if.cmd_ready), 0);
    check("rst_tag_read", int'(bus_if.tag_read), 0);
    check("rst_tag_write", int'(bus_if.tag_write), 0);
    check("rst_wb_req", int'(bus_if.wb_req), 0);
    check("rst_valid_out", int'(bus_if.tag_valid_out), 0);
    check("rst_tag_set", int'(bus_if.tag_set), 0);
    check("rst_tag_way", int'(bus_if.tag_way), 0);
    #1 rest = 1'b1;
    @(negedge clk);

    // Init straight after reset.
    push_expect(C_INIT);
    drive_walk(C_INIT, C_NOP, C_NOP);
    repeat (2) @(negedge clk);

    // Write-back: lines 3 and 6 dirty, ack after 2 extra cycles.
    for (int i = 0; i < N; i++) begin
      ram_v[i] = 1; ram_d[i] = (i == 3 || i == 6); wb_dly[i] = 2;
    end
    push_expect(C_WB);
    drive_walk(C_WB, C_NOP, C_NOP);
    for (int i = 0; i < N; i++) check("wb_ram_valid", int'(ram_v[i]), 1);
    check("wb_line3_clean", int'(ram_d[3]), 0);
    repeat (2) @(negedge clk);

    // Clear with mixed lines; cmd switched to wb during the walk.
    for (int i = 0; i < N; i++) begin
      ram_v[i] = (i != 0); ram_d[i] = (i == 2); wb_dly[i] = 1;
    end
    ram_d[0] = 1;
    push_expect(C_CLEAR);
    drive_walk(C_CLEAR, C_WB, C_NOP);
    repeat (6) @(negedge clk);
    check("no_restart_busy", int'(bus_if.busy), 0);

    // Unknown encodings are ignored.
    bus_if.cmd = 3'd5;
    repeat (3) @(negedge clk);
    check("unknown_cmd_busy", int'(bus_if.busy), 0);
    bus_if.cmd = 3'd7;
    repeat (3) @(negedge clk);
    check("unknown_cmd_busy2", int'(bus_if.busy), 0);
    bus_if.cmd = C_NOP;
    @(negedge clk);

    // Back-to-back: wb presented on the cycle after cmd_ready.
    rand_ram();
    push_expect(C_CLEAR);
    drive_walk(C_CLEAR, 3'($urandom), C_WB);
    for (int i = 0; i < N; i++) ram_d[i] = 1'($urandom);  // ram_v now all 0
    push_expect(C_WB);
    wait_busy(g);
    check("b2b_idle_gap", g, 2);
    bus_if.cmd = C_NOP;
    wait_ready();
    repeat (2) @(negedge clk);

    // Reset while in WB_REQ.
    for (int i = 0; i < N; i++) begin
      ram_v[i] = 1; ram_d[i] = 1; wb_dly[i] = 3;
    end
    push_expect(C_WB);
    bus_if.cmd = C_WB;
    begin : wait_wb
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (bus_if.wb_req) disable wait_wb;
      end
      flag("wb_req_timeout");
    end
    bus_if.cmd = C_NOP;
    #2 rest = 1'b0;
    #1;
    check("abort_wb_req", int'(bus_if.wb_req), 0);
    check("abort_busy", int'(bus_if.busy), 0);
    check("abort_tag_write", int'(bus_if.tag_write), 0);
    check("abort_cmd_ready", int'(bus_if.cmd_ready), 0);
    exp_q.delete();
    cyc_q.delete();
    repeat (2) @(negedge clk);
    #2 rest = 1'b1;
    @(negedge clk);
    push_expect(C_INIT);
    drive_walk(C_INIT, C_CLEAR, C_NOP);
    repeat (3) @(negedge clk);

    // Randomized walks.
    for (int t = 0; t < 16; t++) begin
      rand_ram();
      case ($urandom_range(0, 4))
        0:       op = C_INIT;
        1, 2:    op = C_CLEAR;
        default: op = C_WB;
      endcase
      push_expect(op);
      drive_walk(op, 3'($urandom), C_NOP);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("sb_events_drained", exp_q.size(), 0);
    check("sb_walks_drained", cyc_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cache_maint_seq.md
Name: cache_maint_seq

Overview:
Maintenance sequencer between the cache control-register block and the cache tag/state RAM. It accepts the 3-bit maintenance command (init / clear / write-back) and walks every set and way of the cache. For each line it reads the tag state, requests write-back of dirty lines, and rewrites the valid/dirty bits. It returns cmd_ready when the walk is complete, and asserts busy so the CPU-side cache port stalls while a walk is in progress.

Parameters:
SET_NUM, 64, number of cache sets; power of two, at least 2.
WAY_NUM, 4, ways per set; power of two, at least 1.
SET_W, $clog2(SET_NUM), set index width (derived localparam).
WAY_W, max(1,$clog2(WAY_NUM)), way index width (derived localparam).

Ports:
clk  input  1  clock
rest  input  1  reset, asynchronous, active-low
cmd  input  3  maintenance command; encodings are the `cache_ctr_cmd_nop/init/clear/wb macros from cache_define.sv
cmd_ready  output  1  one-cycle pulse when the command is complete
busy  output  1  high whenever the sequencer is not in IDLE
tag_set  output  SET_W  set index for tag RAM and write-back access
tag_way  output  WAY_W  way index for tag RAM and write-back access
tag_read  output  1  tag-state read strobe; data returns on the next cycle
tag_valid_in  input  1  valid bit read back, sampled in CHECK
tag_dirty_in  input  1  dirty bit read back, sampled in CHECK
tag_write  output  1  tag-state write strobe
tag_valid_out  output  1  valid bit to write
tag_dirty_out  output  1  dirty bit to write
wb_req  output  1  request write-back of line (tag_set, tag_way)
wb_ack  input  1  write-back complete

Behaviour:
- One clock domain: clk. Reset rest is asynchronous and active-low.
- On reset:
  - state=IDLE and idx=0.
  - All outputs are 0: cmd_ready, busy, tag_read, tag_write, tag_valid_out, tag_dirty_out, wb_req, tag_set, tag_way.
- Reset asserted mid-walk aborts immediately. No partial write completes and no cmd_ready is issued.
- Walk index:
  - idx register width SET_W+WAY_W.
  - tag_way = idx[WAY_W-1:0]; tag_set = idx upper bits.
  - When WAY_NUM=1, tag_way is 0.
  - Walk runs 0 to SET_NUM*WAY_NUM-1 in ascending order. No wrap: the last index goes to DONE.
- Outputs are Moore-decoded from the state and idx registers. All state changes occur on posedge clk.
- IDLE:
  - If cmd != nop, latch cmd into op and clear idx.
  - init goes to INIT_WR; clear or wb goes to READ.
  - Unknown encodings are ignored and the state stays IDLE.
- Latched op is fixed for the whole walk. cmd changes during a walk are ignored.
- INIT_WR:
  - tag_write=1, valid_out=0, dirty_out=0, one line per cycle.
  - Last idx goes to DONE; otherwise idx+1 and stay in INIT_WR.
- READ: tag_read=1 for one cycle, then CHECK.
- CHECK:
  - valid&dirty: go to WB_REQ.
  - Otherwise, op=clear: go to UPDATE.
  - Otherwise, op=wb: advance (last idx to DONE, else idx+1 and READ).
- WB_REQ:
  - wb_req=1; tag_set and tag_way held stable.
  - Stay in WB_REQ until wb_ack is sampled high, then go to UPDATE. Minimum 1 cycle.
  - wb_ack outside WB_REQ is ignored.
- UPDATE:
  - tag_write=1 for one cycle.
  - op=wb writes valid=1, dirty=0. op=clear writes valid=0, dirty=0.
  - Then advance as in CHECK.
- DONE:
  - cmd_ready=1 for exactly one cycle, busy=1, then IDLE.
  - The controller drops cmd to nop on the same edge, so IDLE sees nop and does not restart.
- busy=1 in every state except IDLE.
- Outputs are mutually exclusive: tag_read, tag_write and wb_req are never high in the same cycle.
- Latencies:
  - init: N write cycles + 1 (DONE); first write 1 cycle after cmd is sampled.
  - wb/clear, per line: 2 cycles (READ+CHECK), plus wait cycles if dirty, plus 1 if written.
- An init command arriving directly after reset is accepted normally.

Test Plan:
- init, SET_NUM=4, WAY_NUM=2 -> tag_write high 8 consecutive cycles:
  - idx 0..7 in order, set 0..3 and way 0/1 low-bit-first, valid_out=dirty_out=0.
  - cmd_ready one cycle after the last write; busy low the following cycle.
- wb, lines idx3 and idx6 valid+dirty, all others valid+clean, wb_ack delayed 2 cycles -> exactly two wb_req bursts (set1/way1 and set3/way0):
  - wb_req held 3 cycles each.
  - Each burst followed by tag_write with valid=1, dirty=0.
  - No tag_write for clean lines.
  - Total walk 8*2+2*(3+1) = 24 cycles, then DONE.
- clear, mixed lines (idx0 invalid, idx2 dirty, rest valid clean) -> tag_write for every line with valid=0, dirty=0; wb_req only for idx2; single cmd_ready.
- cmd switched from clear to wb mid-walk -> behaviour unchanged, clear semantics to the end; no restart after DONE while cmd=nop.
- rest pulsed low while in WB_REQ -> wb_req, busy and tag_write drop asynchronously; no cmd_ready. A new init after reset walks from idx 0.
- Back-to-back: a wb command presented the cycle after cmd_ready -> accepted from IDLE on that cycle; second walk starts at idx 0 with one IDLE cycle between walks.
